// File: rtl/cpu_mem_server_if.sv
// CPU bus and boot-loader byte stream between cpu_mem_server (slave) and the CPU/loader (master).
interface cpu_mem_server_if;
  logic [7:0]  PC;
  logic [7:0]  ADDR;
  logic [7:0]  WDATA;
  logic        MW;
  logic [15:0] Iin;
  logic [7:0]  Din;
  logic        EN_L;
  logic        CPU_RST;
  logic        LD_VALID;
  logic [7:0]  LD_BYTE;
  logic        LD_LAST;
  logic        LD_READY;
  logic        LD_OVF;

  modport master (
    output PC, ADDR, WDATA, MW, LD_VALID, LD_BYTE, LD_LAST,
    input  Iin, Din, EN_L, CPU_RST, LD_READY, LD_OVF
  );

  modport slave (
    input  PC, ADDR, WDATA, MW, LD_VALID, LD_BYTE, LD_LAST,
    output Iin, Din, EN_L, CPU_RST, LD_READY, LD_OVF
  );
endinterface

// File: rtl/cpu_mem_server.sv
// Instruction/data memory server with boot loader (LOAD -> RELEASE -> RUN) for the 8-bit CPU.
// Optional HR_MMIO_EN: RUN cycle counter snapshot readable at data addresses FE/FF.
module cpu_mem_server #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_DEPTH = 256
) (
  input  logic            CLK,
  input  logic            RESET,
  cpu_mem_server_if.slave bus
);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t      state, state_nx;
  logic [6:0]  wp, wp_nx;
  logic        ph_hi, ph_hi_nx;
  logic        ld_ovf, ld_ovf_nx;
  logic        en_l, cpu_rst, ld_ready;
  logic [7:0]  lo_byte;
  logic        hs;
  logic        wp_at_end;
  logic        imem_we;
  logic [15:0] imem_wdata;

  logic [15:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_DEPTH];

  assign hs        = bus.LD_VALID && ld_ready;
  assign wp_at_end = ({1'b0, wp} == 8'(IMEM_WORDS - 1));

  always_comb begin
    state_nx   = state;
    wp_nx      = wp;
    ph_hi_nx   = ph_hi;
    ld_ovf_nx  = ld_ovf;
    imem_we    = 1'b0;
    imem_wdata = {bus.LD_BYTE, lo_byte};
    case (state)
      S_LOAD: begin
        if (hs) begin
          if (!ph_hi) begin
            // A final odd byte becomes a zero-extended word of its own
            if (bus.LD_LAST) begin
              imem_we    = 1'b1;
              imem_wdata = {8'h00, bus.LD_BYTE};
              state_nx   = S_RELEASE;
            end else begin
              ph_hi_nx = 1'b1;
            end
          end else begin
            imem_we  = 1'b1;
            ph_hi_nx = 1'b0;
            wp_nx    = wp + 7'd1;
            if (bus.LD_LAST) begin
              state_nx = S_RELEASE;
            end else if (wp_at_end) begin
              ld_ovf_nx = 1'b1;
              state_nx  = S_RELEASE;
            end
          end
        end
      end
      S_RELEASE: state_nx = S_RUN;
      S_RUN:     state_nx = S_RUN;
      default:   state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_LOAD;
      wp       <= '0;
      ph_hi    <= 1'b0;
      ld_ovf   <= 1'b0;
      en_l     <= 1'b1;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      wp       <= wp_nx;
      ph_hi    <= ph_hi_nx;
      ld_ovf   <= ld_ovf_nx;
      en_l     <= (state_nx != S_RUN);
      cpu_rst  <= (state_nx != S_RUN);
      ld_ready <= (state_nx == S_LOAD);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && state == S_LOAD && hs && !ph_hi) lo_byte <= bus.LD_BYTE;
  end

  always_ff @(posedge CLK) begin
    if (imem_we && !RESET) imem[wp] <= imem_wdata;
  end

  assign bus.EN_L     = en_l;
  assign bus.CPU_RST  = cpu_rst;
  assign bus.LD_READY = ld_ready;
  assign bus.LD_OVF   = ld_ovf;

  // The CPU sees NOPs (all-zero) while the image is still arriving
  assign bus.Iin = (state != S_LOAD && {1'b0, bus.PC[7:1]} < 8'(IMEM_WORDS))
                   ? imem[bus.PC[7:1]] : 16'h0000;

  logic       run_wr;
  logic       dmem_hit;
  logic       dmem_we;
  logic [7:0] dmem_rd;

  assign run_wr   = bus.MW && state == S_RUN && !RESET;
  assign dmem_hit = {1'b0, bus.ADDR} < 9'(DMEM_DEPTH);
  assign dmem_rd  = dmem_hit ? dmem[bus.ADDR] : 8'h00;

`ifdef HR_MMIO_EN
  logic [15:0] cyc;
  logic [15:0] snap;
  logic        mmio_sel;

  assign mmio_sel = (bus.ADDR[7:1] == 7'h7F);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cyc  <= '0;
      snap <= '0;
    end else begin
      if (state == S_RUN) cyc <= cyc + 16'd1;
      if (run_wr && bus.ADDR == 8'hFE) snap <= cyc;
    end
  end

  assign dmem_we = run_wr && dmem_hit && !mmio_sel;
  assign bus.Din = mmio_sel ? (bus.ADDR[0] ? snap[15:8] : snap[7:0]) : dmem_rd;
`else
  assign dmem_we = run_wr && dmem_hit;
  assign bus.Din = dmem_rd;
`endif

  always_ff @(posedge CLK) begin
    if (dmem_we) dmem[bus.ADDR] <= bus.WDATA;
  end

endmodule

// File: tb/tb_cpu_mem_server.sv
// Randomized bench for cpu_mem_server against a byte-stream/array reference model.
module tb_cpu_mem_server;

  typedef logic [7:0] bq_t[$];

  localparam int P_LOAD = 0;
  localparam int P_REL  = 1;
  localparam int P_RUN  = 2;

  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   bad   = 0;
  bit   armed = 1'b0;

  cpu_mem_server_if bus ();

  cpu_mem_server dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase, byte count of the image, memories with known-valid maps
  int          m_ph;
  bit          m_rdy;
  bit          m_ovf;
  int          m_nb;
  logic [7:0]  m_pend;
  logic [15:0] m_imem [128];
  bit          m_iv   [128];
  logic [7:0]  m_dmem [256];
  bit          m_dv   [256];
`ifdef HR_MMIO_EN
  logic [15:0] m_cyc;
  logic [15:0] m_snap;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    int w;
    if (RESET) begin
      m_ph  = P_LOAD;
      m_rdy = 1'b0;
      m_ovf = 1'b0;
      m_nb  = 0;
`ifdef HR_MMIO_EN
      m_cyc  = 16'h0;
      m_snap = 16'h0;
`endif
    end else if (m_ph == P_LOAD) begin
      if (bus.LD_VALID && m_rdy) begin
        w = m_nb / 2;
        if (m_nb % 2 == 0) begin
          m_pend = bus.LD_BYTE;
          if (bus.LD_LAST) begin
            m_imem[w] = {8'h00, bus.LD_BYTE};
            m_iv[w]   = 1'b1;
            m_ph      = P_REL;
          end
        end else begin
          m_imem[w] = {bus.LD_BYTE, m_pend};
          m_iv[w]   = 1'b1;
          if (bus.LD_LAST) m_ph = P_REL;
          else if (w == 127) begin
            m_ovf = 1'b1;
            m_ph  = P_REL;
          end
        end
        m_nb++;
      end
      m_rdy = (m_ph == P_LOAD);
    end else if (m_ph == P_REL) begin
      m_ph = P_RUN;
    end else begin
      if (bus.MW) begin
`ifdef HR_MMIO_EN
        if (bus.ADDR == 8'hFE) m_snap = m_cyc;
        else if (bus.ADDR != 8'hFF) begin
          m_dmem[bus.ADDR] = bus.WDATA;
          m_dv[bus.ADDR]   = 1'b1;
        end
`else
        m_dmem[bus.ADDR] = bus.WDATA;
        m_dv[bus.ADDR]   = 1'b1;
`endif
      end
`ifdef HR_MMIO_EN
      m_cyc = m_cyc + 16'd1;
`endif
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("en_l",     {31'b0, bus.EN_L},     {31'b0, m_ph != P_RUN});
      chk("cpu_rst",  {31'b0, bus.CPU_RST},  {31'b0, m_ph != P_RUN});
      chk("ld_ready", {31'b0, bus.LD_READY}, {31'b0, m_ph == P_LOAD && m_rdy});
      chk("ld_ovf",   {31'b0, bus.LD_OVF},   {31'b0, m_ovf});
      if (m_ph == P_LOAD) chk("iin_load", {16'b0, bus.Iin}, 32'h0);
      else if (m_ph == P_RUN && m_iv[bus.PC[7:1]])
        chk("iin_run", {16'b0, bus.Iin}, {16'b0, m_imem[bus.PC[7:1]]});
`ifdef HR_MMIO_EN
      if (bus.ADDR == 8'hFE) chk("din_snap_lo", {24'b0, bus.Din}, {24'b0, m_snap[7:0]});
      else if (bus.ADDR == 8'hFF) chk("din_snap_hi", {24'b0, bus.Din}, {24'b0, m_snap[15:8]});
      else
`endif
      if (m_dv[bus.ADDR]) chk("din", {24'b0, bus.Din}, {24'b0, m_dmem[bus.ADDR]});
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    armed = 1'b1;
  endtask

  task automatic send_bytes(input bq_t bq, input bit last_flag);
    for (int i = 0; i < bq.size(); i++) begin
      int budget;
      bit acc;
      if ($urandom_range(0, 3) == 0) begin
        bus.LD_VALID = 1'b0;
        bus.LD_LAST  = 1'b0;
        @(posedge CLK); #1;
      end
      bus.LD_VALID = 1'b1;
      bus.LD_BYTE  = bq[i];
      bus.LD_LAST  = last_flag && (i == bq.size() - 1);
      acc    = 1'b0;
      budget = 20;
      while (!acc && budget > 0) begin
        acc = bus.LD_READY;
        @(posedge CLK); #1;
        budget--;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL ld_accept: byte %0d not accepted, got timeout expected handshake", i);
      end
    end
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      bus.PC       = 8'($urandom);
      bus.ADDR     = ($urandom_range(0, 7) == 0) ? {7'h7F, 1'($urandom)}
                                                 : 8'(8'h30 + $urandom_range(0, 31));
      bus.WDATA    = 8'($urandom);
      bus.MW       = 1'($urandom);
      bus.LD_VALID = 1'($urandom);
      bus.LD_BYTE  = 8'($urandom);
      bus.LD_LAST  = 1'($urandom);
      @(posedge CLK); #1;
    end
    bus.MW       = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bq;
    int  budget;
    RESET        = 1'b1;
    bus.PC       = 8'h00;
    bus.ADDR     = 8'h00;
    bus.WDATA    = 8'h00;
    bus.MW       = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_BYTE  = 8'h00;
    bus.LD_LAST  = 1'b0;

    // 1: basic load and release
    @(posedge CLK); #1;
    do_reset();
    chk("rst_en_l",     {31'b0, bus.EN_L},     32'h1);
    chk("rst_cpu_rst",  {31'b0, bus.CPU_RST},  32'h1);
    chk("rst_ld_ready", {31'b0, bus.LD_READY}, 32'h0);
    chk("rst_ld_ovf",   {31'b0, bus.LD_OVF},   32'h0);
    bq = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_bytes(bq, 1'b1);
    chk("rel_cpu_rst",  {31'b0, bus.CPU_RST},  32'h1);
    chk("rel_ld_ready", {31'b0, bus.LD_READY}, 32'h0);
    @(posedge CLK); #1;
    chk("run_en_l",    {31'b0, bus.EN_L},    32'h0);
    chk("run_cpu_rst", {31'b0, bus.CPU_RST}, 32'h0);
    bus.PC = 8'h02; #1;
    chk("iin_pc02", {16'b0, bus.Iin}, 32'h5678);
    bus.PC = 8'h00; #1;
    chk("iin_pc00", {16'b0, bus.Iin}, 32'h1234);

    // 2: store in RUN, old byte visible in the write cycle; MW ignored while loading
    bus.ADDR = 8'h40; bus.WDATA = 8'h3C; bus.MW = 1'b1;
    @(posedge CLK); #1;
    bus.WDATA = 8'hA5; #1;
    chk("din_old", {24'b0, bus.Din}, 32'h3C);
    @(posedge CLK); #1;
    bus.MW = 1'b0; #1;
    chk("din_new", {24'b0, bus.Din}, 32'hA5);
    do_reset();
    bus.ADDR = 8'h40; bus.WDATA = 8'hFF; bus.MW = 1'b1;
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(bq, 1'b1);
    @(posedge CLK); #1;
    bus.MW = 1'b0; #1;
    chk("din_load_mw", {24'b0, bus.Din}, 32'hA5);
    run_rand(200);

    // 3: odd-length image
    do_reset();
    bq = '{8'hAA, 8'hBB, 8'hCC};
    send_bytes(bq, 1'b1);
    @(posedge CLK); #1;
    chk("odd_run", {31'b0, bus.EN_L}, 32'h0);
    bus.PC = 8'h00; #1;
    chk("odd_w0", {16'b0, bus.Iin}, 32'hBBAA);
    bus.PC = 8'h02; #1;
    chk("odd_w1", {16'b0, bus.Iin}, 32'h00CC);
    run_rand(50);

    // 4: overflow, streaming back-to-back without LD_LAST
    do_reset();
    budget = 10;
    while (!bus.LD_READY && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
    end
    chk("ovf_ready_seen", {31'b0, bus.LD_READY}, 32'h1);
    for (int i = 0; i < 258; i++) begin
      bus.LD_VALID = 1'b1;
      bus.LD_BYTE  = 8'(i);
      bus.LD_LAST  = 1'b0;
      @(posedge CLK); #1;
    end
    bus.LD_VALID = 1'b0;
    chk("ovf_flag",  {31'b0, bus.LD_OVF},   32'h1);
    chk("ovf_ready", {31'b0, bus.LD_READY}, 32'h0);
    chk("ovf_run",   {31'b0, bus.EN_L},     32'h0);
    bus.PC = 8'hFE; #1;
    chk("ovf_w127", {16'b0, bus.Iin}, 32'hFFFE);
    bus.PC = 8'h00; #1;
    chk("ovf_w0", {16'b0, bus.Iin}, 32'h0100);
    run_rand(300);

    // 5: reset mid-load then reload
    do_reset();
    bq = '{8'h01, 8'h02, 8'h03};
    send_bytes(bq, 1'b0);
    do_reset();
    chk("reload_ovf_clr", {31'b0, bus.LD_OVF}, 32'h0);
    bq = '{8'h11, 8'h22};
    send_bytes(bq, 1'b1);
    @(posedge CLK); #1;
    bus.PC = 8'h00; #1;
    chk("reload_w0", {16'b0, bus.Iin}, 32'h2211);

    // 6: FE address behaviour
    do_reset();
    send_bytes(bq, 1'b1);
    @(posedge CLK); #1;
    repeat (10) @(posedge CLK);
    #1;
    bus.ADDR = 8'hFE; bus.WDATA = 8'h5A; bus.MW = 1'b1;
    @(posedge CLK); #1;
    bus.MW = 1'b0; #1;
`ifdef HR_MMIO_EN
    chk("snap_lo", {24'b0, bus.Din}, 32'h0A);
    bus.ADDR = 8'hFF; #1;
    chk("snap_hi", {24'b0, bus.Din}, 32'h00);
`else
    chk("fe_ram", {24'b0, bus.Din}, 32'h5A);
`endif
    run_rand(100);

    @(posedge CLK); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
